// File: rtl/scope_capture_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module  : scope_capture_ctrl_if
// Brief   : Sample stream in / double-buffered RAM write port out, bundled
//           for the scope capture sequencer.
// Revision: 1.0 - initial release
// ============================================================================
interface scope_capture_ctrl_if #(
  parameter int SAMPLE_W = 6,
  parameter int ADDR_W   = 5
);
  logic [SAMPLE_W-1:0] sample_in;
  logic                sample_valid;
  logic                wr_en;
  logic                wr_bank;
  logic [ADDR_W-1:0]   wr_addr;
  logic [SAMPLE_W-1:0] wr_data;

  // Sample source and RAM side (drives samples, observes writes)
  modport master (
    output sample_in, sample_valid,
    input  wr_en, wr_bank, wr_addr, wr_data
  );

  // Capture controller side
  modport slave (
    input  sample_in, sample_valid,
    output wr_en, wr_bank, wr_addr, wr_data
  );
endinterface
`default_nettype wire

// File: rtl/scope_capture_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : scope_capture_ctrl
// Brief   : Level-crossing triggered capture of a fixed-length record into
//           one bank of a double-buffered sample RAM; the bank is handed to
//           the display on the next vsync rising edge after completion.
// Revision: 1.0 - initial release
// ============================================================================
module scope_capture_ctrl #(
  parameter int SAMPLE_W    = 6,
  parameter int ADDR_W      = 5,
  parameter int AUTO_FRAMES = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                enable,
  input  logic                single,
  input  logic                arm,
  input  logic                auto_en,
  input  logic                trig_rising,
  input  logic [SAMPLE_W-1:0] trig_level,
  input  logic                vsync,
  output logic                disp_bank,
  output logic                frame_swap,
  output logic [1:0]          state,
  scope_capture_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARM     = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_DONE    = 2'd3
  } state_t;

  localparam logic [7:0]        C_AUTO_MAX = 8'(AUTO_FRAMES);
  localparam logic [ADDR_W-1:0] C_ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  state_t              r_state;
  state_t              w_next;
  logic                r_vsync_d;
  logic [SAMPLE_W-1:0] r_prev;
  logic                r_prev_valid;
  logic [7:0]          r_auto_cnt;
  logic [ADDR_W-1:0]   r_addr;        // address of the next capture write
  logic                r_wr_en;
  logic [ADDR_W-1:0]   r_wr_addr;
  logic [SAMPLE_W-1:0] r_wr_data;
  logic                r_disp_bank;
  logic                r_frame_swap;

  logic                w_vsync_edge;
  logic                w_cross;
  logic                w_auto_fire;
  logic                w_write;
  logic [ADDR_W-1:0]   w_wr_addr;
  logic [ADDR_W-1:0]   w_addr_nxt;
  logic                w_enter_arm;
  logic                w_swap;
  logic                w_cnt_inc;

  assign w_vsync_edge = vsync & ~r_vsync_d;

  // Crossing needs two consecutive accepted samples in the current arming.
  assign w_cross = bus.sample_valid && r_prev_valid &&
                   (trig_rising ? (r_prev <  trig_level && bus.sample_in >= trig_level)
                                : (r_prev >= trig_level && bus.sample_in <  trig_level));

  assign w_auto_fire = auto_en && (r_auto_cnt == C_AUTO_MAX) && bus.sample_valid;

  // State register
  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  // Next-state and per-cycle control decisions
  always_comb begin
    w_next      = r_state;
    w_write     = 1'b0;
    w_wr_addr   = r_addr;
    w_addr_nxt  = r_addr;
    w_enter_arm = 1'b0;
    w_swap      = 1'b0;
    w_cnt_inc   = 1'b0;
    if (!enable) begin
      // Abort: partial record is dropped, display bank is left alone.
      w_next = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (!single || arm) begin
            w_next      = ST_ARM;
            w_enter_arm = 1'b1;
          end
        end
        ST_ARM: begin
          // A trigger in the same cycle as a vsync edge takes priority.
          if (w_cross || w_auto_fire) begin
            w_write    = 1'b1;
            w_wr_addr  = '0;
            w_addr_nxt = C_ADDR_ONE;
            w_next     = ST_CAPTURE;
          end else if (w_vsync_edge && r_auto_cnt != C_AUTO_MAX) begin
            w_cnt_inc = 1'b1;
          end
        end
        ST_CAPTURE: begin
          // A vsync edge here is deliberately ignored; the swap waits a frame.
          if (bus.sample_valid) begin
            w_write    = 1'b1;
            w_wr_addr  = r_addr;
            w_addr_nxt = r_addr + 1'b1;
            if (r_addr == '1) w_next = ST_DONE;
          end
        end
        ST_DONE: begin
          if (w_vsync_edge) begin
            w_swap = 1'b1;
            if (single) begin
              w_next = ST_IDLE;
            end else begin
              w_next      = ST_ARM;
              w_enter_arm = 1'b1;
            end
          end
        end
        default: w_next = ST_IDLE;
      endcase
    end
  end

  // Trigger history, auto counter, capture address and registered RAM writes
  always_ff @(posedge clk) begin
    if (rst) begin
      r_vsync_d    <= 1'b0;
      r_prev       <= '0;
      r_prev_valid <= 1'b0;
      r_auto_cnt   <= '0;
      r_addr       <= '0;
      r_wr_en      <= 1'b0;
      r_wr_addr    <= '0;
      r_wr_data    <= '0;
      r_disp_bank  <= 1'b0;
      r_frame_swap <= 1'b0;
    end else begin
      r_vsync_d <= vsync;
      if (bus.sample_valid) begin
        r_prev       <= bus.sample_in;
        r_prev_valid <= 1'b1;
      end
      if (w_enter_arm) begin
        r_prev_valid <= 1'b0;
        r_auto_cnt   <= '0;
      end else if (w_cnt_inc) begin
        r_auto_cnt <= r_auto_cnt + 8'd1;
      end
      r_addr  <= w_addr_nxt;
      r_wr_en <= w_write;
      if (w_write) begin
        r_wr_addr <= w_wr_addr;
        r_wr_data <= bus.sample_in;
      end
      r_frame_swap <= w_swap;
      if (w_swap) r_disp_bank <= ~r_disp_bank;
    end
  end

  assign state       = r_state;
  assign disp_bank   = r_disp_bank;
  assign frame_swap  = r_frame_swap;
  assign bus.wr_en   = r_wr_en;
  assign bus.wr_bank = ~r_disp_bank;
  assign bus.wr_addr = r_wr_addr;
  assign bus.wr_data = r_wr_data;

endmodule
`default_nettype wire

// File: tb/tb_scope_capture_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_scope_capture_ctrl
// Brief   : Self-checking bench for scope_capture_ctrl; expected RAM writes
//           are queued as stimulus is driven and matched as writes appear.
// Revision: 1.0 - initial release
// ============================================================================
module tb_scope_capture_ctrl;

  localparam int SAMPLE_W = 6;
  localparam int ADDR_W   = 5;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic                enable = 1'b0;
  logic                single = 1'b0;
  logic                arm = 1'b0;
  logic                auto_en = 1'b0;
  logic                trig_rising = 1'b1;
  logic [SAMPLE_W-1:0] trig_level = '0;
  logic                vsync = 1'b0;
  logic                disp_bank;
  logic                frame_swap;
  logic [1:0]          state;

  scope_capture_ctrl_if #(.SAMPLE_W(SAMPLE_W), .ADDR_W(ADDR_W)) bus_if ();

  scope_capture_ctrl #(.SAMPLE_W(SAMPLE_W), .ADDR_W(ADDR_W), .AUTO_FRAMES(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .enable      (enable),
    .single      (single),
    .arm         (arm),
    .auto_en     (auto_en),
    .trig_rising (trig_rising),
    .trig_level  (trig_level),
    .vsync       (vsync),
    .disp_bank   (disp_bank),
    .frame_swap  (frame_swap),
    .state       (state),
    .bus         (bus_if.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [ADDR_W-1:0]   addr;
    logic [SAMPLE_W-1:0] data;
    logic                bank;
  } wr_t;

  typedef struct {
    logic [SAMPLE_W-1:0] sample;
    bit                  wr;
    logic [ADDR_W-1:0]   addr;
    logic [1:0]          st;
  } vec_t;

  wr_t exp_q[$];
  wr_t got;
  int  checks   = 0;
  int  errors   = 0;
  int  swap_cnt = 0;

  // Scoreboard: every observed write must match the head of the queue.
  always @(negedge clk) begin
    if (frame_swap) swap_cnt++;
    if (bus_if.wr_en) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write: got addr=%0d data=%0d bank=%0d, required no write",
                 bus_if.wr_addr, bus_if.wr_data, bus_if.wr_bank);
      end else begin
        got = exp_q.pop_front();
        if (bus_if.wr_addr !== got.addr || bus_if.wr_data !== got.data ||
            bus_if.wr_bank !== got.bank) begin
          errors++;
          $display("FAIL write: got addr=%0d data=%0d bank=%0d, required addr=%0d data=%0d bank=%0d",
                   bus_if.wr_addr, bus_if.wr_data, bus_if.wr_bank, got.addr, got.data, got.bank);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus_if.sample_valid = 1'b0;
    bus_if.sample_in    = '0;
    vsync = 1'b0;
    arm   = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // One accepted sample every two clocks.
  task automatic send_sample(input logic [SAMPLE_W-1:0] v);
    bus_if.sample_in    = v;
    bus_if.sample_valid = 1'b1;
    tick();
    bus_if.sample_valid = 1'b0;
    tick();
  endtask

  task automatic vsync_pulse();
    vsync = 1'b1;
    tick();
    vsync = 1'b0;
    tick();
  endtask

  task automatic push_exp(input int addr, input int data, input logic bank);
    wr_t w;
    w.addr = ADDR_W'(addr);
    w.data = SAMPLE_W'(data);
    w.bank = bank;
    exp_q.push_back(w);
  endtask

  task automatic arm_pulse();
    arm = 1'b1;
    tick();
    arm = 1'b0;
    tick();
  endtask

  vec_t fall_vec[5];

  initial begin
    bus_if.sample_in    = '0;
    bus_if.sample_valid = 1'b0;

    fall_vec[0] = '{6'd40, 1'b0, 5'd0, 2'd1};
    fall_vec[1] = '{6'd30, 1'b0, 5'd0, 2'd1};
    fall_vec[2] = '{6'd21, 1'b0, 5'd0, 2'd1};
    fall_vec[3] = '{6'd19, 1'b1, 5'd0, 2'd2};
    fall_vec[4] = '{6'd10, 1'b1, 5'd1, 2'd2};

    // ---- Reset state ----
    do_reset();
    check("reset_state", int'(state), 0);
    check("reset_disp_bank", int'(disp_bank), 0);
    check("reset_wr_bank", int'(bus_if.wr_bank), 1);
    check("reset_wr_en", int'(bus_if.wr_en), 0);
    check("reset_frame_swap", int'(frame_swap), 0);

    // ---- Rising trigger, continuous ----
    enable = 1'b1; single = 1'b0; trig_level = 6'd32; trig_rising = 1'b1; auto_en = 1'b0;
    tick();
    check("rise_arm_state", int'(state), 1);
    for (int i = 0; i < 32; i++) push_exp(i, 32 + i, 1'b1);
    for (int i = 0; i < 64; i++) send_sample(SAMPLE_W'(i));
    check("rise_done_state", int'(state), 3);
    check("rise_queue_empty", exp_q.size(), 0);
    vsync_pulse();
    check("rise_swap_count", swap_cnt, 1);
    check("rise_disp_bank", int'(disp_bank), 1);
    check("rise_wr_bank", int'(bus_if.wr_bank), 0);
    check("rise_rearm_state", int'(state), 1);

    // ---- Falling trigger, table-driven ----
    trig_rising = 1'b0; trig_level = 6'd20;
    for (int i = 0; i < 5; i++) begin
      if (fall_vec[i].wr) push_exp(int'(fall_vec[i].addr), int'(fall_vec[i].sample), 1'b0);
      send_sample(fall_vec[i].sample);
      check("fall_state", int'(state), int'(fall_vec[i].st));
    end
    check("fall_queue_empty", exp_q.size(), 0);

    // ---- Reset in the middle of a capture ----
    rst = 1'b1;
    tick();
    check("midrst_state", int'(state), 0);
    check("midrst_disp_bank", int'(disp_bank), 0);
    check("midrst_wr_addr", int'(bus_if.wr_addr), 0);
    check("midrst_wr_data", int'(bus_if.wr_data), 0);
    rst = 1'b0;
    enable = 1'b0;

    // ---- Auto trigger, plus last write coinciding with a vsync edge ----
    do_reset();
    swap_cnt = 0;
    enable = 1'b1; single = 1'b0; auto_en = 1'b1; trig_rising = 1'b1; trig_level = 6'd32;
    tick();
    for (int k = 0; k < 7; k++) begin
      vsync_pulse();
      send_sample(6'd5);
    end
    check("auto_wait_state", int'(state), 1);
    vsync_pulse();
    for (int i = 0; i < 32; i++) push_exp(i, 5, 1'b1);
    for (int i = 0; i < 31; i++) send_sample(6'd5);
    check("auto_capture_state", int'(state), 2);
    bus_if.sample_in = 6'd5;
    bus_if.sample_valid = 1'b1;
    vsync = 1'b1;
    tick();
    bus_if.sample_valid = 1'b0;
    tick();
    tick();
    vsync = 1'b0;
    tick();
    check("bound_no_swap", swap_cnt, 0);
    check("bound_done_state", int'(state), 3);
    check("auto_queue_empty", exp_q.size(), 0);
    vsync_pulse();
    check("bound_swap", swap_cnt, 1);
    check("bound_disp_bank", int'(disp_bank), 1);

    // ---- Single-shot ----
    do_reset();
    auto_en = 1'b0; single = 1'b1; enable = 1'b1; trig_rising = 1'b1; trig_level = 6'd32;
    tick(); tick(); tick();
    check("single_idle_wait", int'(state), 0);
    arm_pulse();
    check("single_armed", int'(state), 1);
    for (int i = 0; i < 32; i++) push_exp(i, 32 + i, 1'b1);
    for (int i = 0; i < 64; i++) send_sample(SAMPLE_W'(i));
    vsync_pulse();
    check("single_idle_after", int'(state), 0);
    check("single_disp_bank", int'(disp_bank), 1);
    for (int i = 0; i < 41; i++) send_sample(SAMPLE_W'(i));
    check("single_stays_idle", int'(state), 0);
    arm_pulse();
    check("single_rearmed", int'(state), 1);
    push_exp(0, 32, 1'b0);
    send_sample(6'd30);
    send_sample(6'd31);
    send_sample(6'd32);
    check("single_capture", int'(state), 2);
    arm_pulse();
    check("single_arm_ignored", int'(state), 2);
    check("single_queue_empty", exp_q.size(), 0);

    // ---- Abort during capture ----
    do_reset();
    single = 1'b0; enable = 1'b1; trig_level = 6'd32; trig_rising = 1'b1;
    tick();
    for (int i = 0; i < 10; i++) push_exp(i, 32 + i, 1'b1);
    for (int i = 0; i < 42; i++) send_sample(SAMPLE_W'(i));
    check("abort_capture_state", int'(state), 2);
    enable = 1'b0;
    tick();
    check("abort_idle", int'(state), 0);
    check("abort_disp_bank", int'(disp_bank), 0);
    send_sample(6'd42);
    send_sample(6'd43);
    check("abort_queue_empty", exp_q.size(), 0);
    enable = 1'b1;
    tick();
    push_exp(0, 32, 1'b1);
    push_exp(1, 33, 1'b1);
    for (int i = 0; i < 34; i++) send_sample(SAMPLE_W'(i));
    check("restart_queue_empty", exp_q.size(), 0);
    check("restart_state", int'(state), 2);

    tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/scope_capture_ctrl.md
Name: scope_capture_ctrl

Overview:
Sequences waveform capture for the VGA scope. Watches an incoming sample stream for a level-crossing trigger and writes a fixed-length record into one bank of a double-buffered sample RAM. At the next vertical-sync edge from the VGA timing generator it swaps that bank to the display side, so the display never reads a half-written record.

Parameters:
SAMPLE_W, 6, sample width in bits; equals vertical resolution of the trace.
ADDR_W, 5, log2 of record length (32 samples, one per 32-pixel column).
AUTO_FRAMES, 8, vsync rising edges spent in ARM before auto-trigger is forced; valid range 1..255.

Ports:
clk  in  1  pixel clock
rst  in  1  synchronous reset, active-high
enable  in  1  run control; low forces IDLE
single  in  1  1 = single-shot mode, 0 = continuous
arm  in  1  one-cycle pulse; re-arms in single-shot mode
auto_en  in  1  enable auto-trigger timeout
trig_rising  in  1  1 = rising-edge trigger, 0 = falling-edge trigger
trig_level  in  SAMPLE_W  trigger threshold, unsigned
sample_in  in  SAMPLE_W  sample data
sample_valid  in  1  qualifies sample_in, at most one per cycle
vsync  in  1  active-high vsync from the timing generator
wr_en  out  1  RAM write strobe
wr_bank  out  1  bank being written
wr_addr  out  ADDR_W  write address
wr_data  out  SAMPLE_W  write data
disp_bank  out  1  bank owned by the display
frame_swap  out  1  one-cycle pulse on bank swap
state  out  2  IDLE=0, ARM=1, CAPTURE=2, DONE=3

Behaviour:
- Reset values:
  - state=IDLE; wr_en=0, wr_addr=0, wr_data=0, frame_swap=0.
  - disp_bank=0, wr_bank=1.
  - Internal: vsync_d=0, prev_valid=0, auto counter=0.
- wr_bank is always the inverse of disp_bank.
- vsync edge: vsync & ~vsync_d, with vsync_d registered every cycle.
- Trigger check: evaluated only when sample_valid && prev_valid. prev is updated on every accepted sample.
  - Rising: prev < trig_level && sample_in >= trig_level.
  - Falling: prev >= trig_level && sample_in < trig_level.
  - Compares are unsigned, SAMPLE_W wide.
- Write timing: write outputs are registered, one cycle after the accepted sample. wr_en stays high for that single cycle.
- IDLE:
  - Go to ARM when enable && (!single || arm).
  - Entering ARM clears the auto counter and prev_valid.
- ARM:
  - The auto counter increments on each vsync edge and saturates at AUTO_FRAMES.
  - Trigger fires on a crossing, or, if auto_en && counter==AUTO_FRAMES, on the next valid sample.
  - The firing sample is written at wr_addr=0, and the state goes to CAPTURE with the next address = 1.
- CAPTURE:
  - Each sample_valid writes at the next address.
  - The sample written at address 2^ADDR_W-1 moves the state to DONE.
  - The address wraps to 0 internally.
- DONE:
  - Samples are ignored (no wr_en).
  - On the first vsync edge: toggle disp_bank (wr_bank follows), pulse frame_swap for one cycle.
  - Then go to IDLE if single, else ARM (clearing the counter and prev_valid).
- Simultaneous events:
  - A vsync edge in the cycle the last sample moves the state to DONE is not a swap: it is sampled in CAPTURE. The swap waits for the following frame.
  - A vsync edge in ARM together with a trigger: the trigger wins, and the counter value is irrelevant.
  - arm while not in IDLE is ignored.
- enable low in any state: state goes to IDLE on the next edge.
  - Any write already registered for that edge still completes.
  - No further writes occur, and a partial record is discarded.
  - disp_bank is unchanged.
- Mode change: single is sampled only on IDLE exit and on DONE exit.
- rst mid-capture: everything returns to reset values on the next clock edge, including disp_bank=0.

Test Plan:
1. Rising trigger: reset, enable=1, single=0, trig_level=32, trig_rising=1; feed a ramp 0..63 with one sample every 2 clk.
   - Trigger on sample 32; wr_addr 0..31 carries data 32..63.
   - Then DONE; at the next vsync edge frame_swap=1 for one cycle, disp_bank 0→1, wr_bank=0, state=ARM.
2. Falling trigger: trig_rising=0, level=20; feed 40, 30, 21, 19, 10.
   - First write is 19 at addr 0; no writes before it.
3. Auto trigger: auto_en=1, AUTO_FRAMES=8, constant input 5, level 32.
   - No write through 7 vsync edges.
   - After the 8th edge, the next sample is written at addr 0 and 32 writes follow.
4. Single-shot: single=1; run one capture.
   - After the swap state=IDLE and further crossings cause no writes.
   - An arm pulse returns the state to ARM and the next crossing captures.
5. Abort: enable dropped after 10 writes in CAPTURE.
   - state=IDLE within 1 clk, at most one more write, disp_bank unchanged.
   - Re-enable restarts at addr 0 on the next trigger.
6. Boundary: the 32nd write and a vsync rising edge in the same cycle.
   - No swap on that edge; the swap occurs on the next vsync edge.
